// File: rtl/lcd_bus_responder.sv
// Display-side responder for an HD44780-style parallel LCD bus: 2x16 character shadow, address counter, busy flag.
// Optional macro LCD_SHIFT_EN adds a display_offset register for entry-mode and cursor/display shifting.
//
// state   | meaning
// ST_FILL | writing 0x20 into all 32 shadow cells (after reset or clear), busy forced high
// ST_IDLE | decoding bus cycles, busy follows the down-counter
module lcd_bus_responder #(
    parameter int SYNC_STAGES       = 2,
    parameter int BUSY_CMD_CYCLES   = 1850,
    parameter int BUSY_CLEAR_CYCLES = 76000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_on,
    input  logic [7:0] lcd_db_in,
    output logic [7:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_char,
    output logic       overrun,
    output logic       display_on,
    output logic [6:0] cursor_addr
);
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;
    localparam int CMAX = (BUSY_CLEAR_CYCLES > BUSY_CMD_CYCLES) ? BUSY_CLEAR_CYCLES : BUSY_CMD_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    logic [11:0] sync_q [SYNC_STAGES];
    logic        on_s, e_s, rs_s, rw_s;
    logic [7:0]  db_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {lcd_on, lcd_e, lcd_rs, lcd_rw, lcd_db_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign {on_s, e_s, rs_s, rw_s, db_s} = sync_q[SYNC_STAGES-1];

    logic          e_prev_q, cap_rs_q, cap_rw_q;
    logic [7:0]    cap_db_q;
    logic [0:0]    state_q, state_d;
    logic [4:0]    fill_idx_q, fill_idx_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic [6:0]    ac_q, ac_d;
    logic          inc_q, inc_d, display_on_q, display_on_d;
    logic          wr_pend_q, wr_pend_d, wr_valid_q, wr_valid_d, overrun_q, overrun_d;
    logic [4:0]    pend_addr_q, pend_addr_d, wr_addr_q, wr_addr_d;
    logic [7:0]    pend_char_q, pend_char_d, wr_char_q, wr_char_d;
    logic [7:0]    shadow_q [32];
    logic          shadow_we;
    logic [4:0]    shadow_waddr;
    logic [7:0]    shadow_wdata;
    logic [5:0]    ac_cell;
    logic          fall, wr_accept, wr_drop, rd_fall;

    // 2-line address map: +1 wraps 0x27->0x40 and 0x67->0x00; out-of-range values land back on a line
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) r = (ac[5:0] >= 6'd39) ? (ac[6] ? 7'h00 : 7'h40) : ac + 7'd1;
        else if (ac[5:0] == 6'd0) r = ac[6] ? 7'h27 : 7'h67;
        else if (ac[5:0] >= 6'd40) r = {ac[6], 6'd39};
        else r = ac - 7'd1;
        return r;
    endfunction

`ifdef LCD_SHIFT_EN
    logic [5:0] offset_q, offset_d;
    logic       shift_q, shift_d;

    function automatic logic [5:0] cell_map(input logic [6:0] ac, input logic [5:0] off);
        logic [5:0] pos, col;
        pos = ac[5:0];
        col = (pos >= off) ? pos - off : pos + 6'd40 - off;
        return {(pos < 6'd40) && (col < 6'd16), ac[6], col[3:0]};
    endfunction

    function automatic logic [5:0] off_step(input logic [5:0] off, input logic left);
        logic [5:0] r;
        if (left) r = (off >= 6'd39) ? 6'd0 : off + 6'd1;
        else      r = (off == 6'd0) ? 6'd39 : off - 6'd1;
        return r;
    endfunction

    assign ac_cell = cell_map(ac_q, offset_q);
`else
    function automatic logic [5:0] cell_map(input logic [6:0] ac);
        return {(ac[5:4] == 2'b00), ac[6], ac[3:0]};
    endfunction

    assign ac_cell = cell_map(ac_q);
`endif

    assign fall      = e_prev_q & ~e_s & on_s;
    assign wr_accept = fall & ~cap_rw_q & ~busy_q;
    assign wr_drop   = fall & ~cap_rw_q & busy_q;
    assign rd_fall   = fall & cap_rw_q;

    always_comb begin
        state_d      = state_q;
        fill_idx_d   = fill_idx_q;
        busy_d       = busy_q;
        busy_cnt_d   = busy_cnt_q;
        ac_d         = ac_q;
        inc_d        = inc_q;
        display_on_d = display_on_q;
        wr_pend_d    = 1'b0;
        pend_addr_d  = pend_addr_q;
        pend_char_d  = pend_char_q;
        wr_valid_d   = wr_pend_q;
        wr_addr_d    = wr_pend_q ? pend_addr_q : wr_addr_q;
        wr_char_d    = wr_pend_q ? pend_char_q : wr_char_q;
        overrun_d    = wr_drop;
        shadow_we    = 1'b0;
        shadow_waddr = fill_idx_q;
        shadow_wdata = 8'h20;
`ifdef LCD_SHIFT_EN
        offset_d     = offset_q;
        shift_d      = shift_q;
`endif
        if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - CW'(1);

        if (state_q == ST_FILL) begin
            busy_d     = 1'b1;
            shadow_we  = 1'b1;
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd31) state_d = ST_IDLE;
        end else begin
            busy_d = (busy_cnt_q != '0);
        end

        if (rd_fall && cap_rs_q) ac_d = ac_step(ac_q, inc_q);

        if (wr_accept) begin
            busy_d     = 1'b1;
            busy_cnt_d = CW'(BUSY_CMD_CYCLES - 1);
            if (cap_rs_q) begin
                ac_d = ac_step(ac_q, inc_q);
                if (ac_cell[5]) begin
                    shadow_we    = 1'b1;
                    shadow_waddr = ac_cell[4:0];
                    shadow_wdata = cap_db_q;
                    wr_pend_d    = 1'b1;
                    pend_addr_d  = ac_cell[4:0];
                    pend_char_d  = cap_db_q;
                end
`ifdef LCD_SHIFT_EN
                if (shift_q) offset_d = off_step(offset_q, inc_q);
`endif
            end else begin
                casez (cap_db_q)
                    8'b0000_0001: begin
                        state_d    = ST_FILL;
                        fill_idx_d = 5'd0;
                        busy_cnt_d = CW'(BUSY_CLEAR_CYCLES - 1);
                        ac_d       = 7'h00;
                        inc_d      = 1'b1;
`ifdef LCD_SHIFT_EN
                        offset_d   = 6'd0;
`endif
                    end
                    8'b0000_001?: begin
                        busy_cnt_d = CW'(BUSY_CLEAR_CYCLES - 1);
                        ac_d       = 7'h00;
`ifdef LCD_SHIFT_EN
                        offset_d   = 6'd0;
`endif
                    end
                    8'b0000_01??: begin
                        inc_d = cap_db_q[1];
`ifdef LCD_SHIFT_EN
                        shift_d = cap_db_q[0];
`endif
                    end
                    8'b0000_1???: display_on_d = cap_db_q[2];
                    8'b0001_????: begin
                        if (!cap_db_q[3]) ac_d = ac_step(ac_q, cap_db_q[2]);
`ifdef LCD_SHIFT_EN
                        else offset_d = off_step(offset_q, ~cap_db_q[2]);
`endif
                    end
                    8'b1???_????: ac_d = cap_db_q[6:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_prev_q     <= 1'b0;
            cap_rs_q     <= 1'b0;
            cap_rw_q     <= 1'b0;
            cap_db_q     <= 8'h00;
            state_q      <= ST_FILL;
            fill_idx_q   <= 5'd0;
            busy_q       <= 1'b0;
            busy_cnt_q   <= '0;
            ac_q         <= 7'h00;
            inc_q        <= 1'b1;
            display_on_q <= 1'b0;
            wr_pend_q    <= 1'b0;
            pend_addr_q  <= 5'd0;
            pend_char_q  <= 8'h00;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_char_q    <= 8'h00;
            overrun_q    <= 1'b0;
`ifdef LCD_SHIFT_EN
            offset_q     <= 6'd0;
            shift_q      <= 1'b0;
`endif
        end else begin
            e_prev_q <= e_s;
            if (e_s) begin
                cap_rs_q <= rs_s;
                cap_rw_q <= rw_s;
                cap_db_q <= db_s;
            end
            state_q      <= state_d;
            fill_idx_q   <= fill_idx_d;
            busy_q       <= busy_d;
            busy_cnt_q   <= busy_cnt_d;
            ac_q         <= ac_d;
            inc_q        <= inc_d;
            display_on_q <= display_on_d;
            wr_pend_q    <= wr_pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_char_q  <= pend_char_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_char_q    <= wr_char_d;
            overrun_q    <= overrun_d;
`ifdef LCD_SHIFT_EN
            offset_q     <= offset_d;
            shift_q      <= shift_d;
`endif
        end
    end

    // shadow RAM needs no reset: the fill walk always follows reset
    always_ff @(posedge clk) begin
        if (shadow_we) shadow_q[shadow_waddr] <= shadow_wdata;
    end

    assign lcd_db_oe   = on_s & e_s & rw_s;
    assign lcd_db_out  = !lcd_db_oe ? 8'h00 :
                         rs_s ? (ac_cell[5] ? shadow_q[ac_cell[4:0]] : 8'h20) : {busy_q, ac_q};
    assign busy        = busy_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_char     = wr_char_q;
    assign overrun     = overrun_q;
    assign display_on  = display_on_q;
    assign cursor_addr = ac_q;
endmodule
